dct_sample_loader: RTL



---
 rtl/dct_sample_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dct_sample_loader.sv
// Serial-to-parallel sample loader for the 8-point DCT front end.
// Gathers eight DW-bit samples into a fill buffer and presents each block on n0..n7 for HOLD_CYCLES cycles.

module dct_sample_lane #(
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          ld,
  output logic [DW-1:0] q
);
  logic [DW-1:0] fb_q;

  // fb_q is the fill slot; q is the presented copy that survives refills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q <= '0;
      q    <= '0;
    end else begin
      if (wr) fb_q <= din;
      if (ld) q    <= fb_q;
    end
  end
endmodule

module dct_sample_loader #(
  parameter int DW          = 14,
  parameter int HOLD_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] n0,
  output logic [DW-1:0] n1,
  output logic [DW-1:0] n2,
  output logic [DW-1:0] n3,
  output logic [DW-1:0] n4,
  output logic [DW-1:0] n5,
  output logic [DW-1:0] n6,
  output logic [DW-1:0] n7,
  output logic          blk_start,
  output logic          blk_busy
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                        state_q, state_d;
  logic [7:0]                    hold_q, hold_d;
  logic [2:0]                    wr_idx;
  logic                          fill_full;
  logic                          accept;
  logic                          xfer;
  logic [NUM_LANES-1:0][DW-1:0]  nq;

  // s_ready comes straight from a flop, so s_valid never reaches it combinationally
  assign s_ready  = ~fill_full;
  assign accept   = s_valid & ~fill_full;
  assign blk_busy = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: if (fill_full) xfer = 1'b1;
      HOLD: begin
        if (hold_q != 8'd0)  hold_d  = hold_q - 8'd1;
        else if (fill_full)  xfer    = 1'b1;
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      state_d = HOLD;
      hold_d  = 8'(HOLD_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      blk_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      blk_start <= xfer;
    end
  end

  // Acceptance and transfer are mutually exclusive since s_ready is low while full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      fill_full <= 1'b0;
    end else if (accept) begin
      wr_idx <= wr_idx + 3'd1;
      if (wr_idx == 3'd7) fill_full <= 1'b1;
    end else if (xfer) begin
      fill_full <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dct_sample_lane #(.DW(DW)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .wr   (accept && (wr_idx == 3'(g))),
      .din  (s_data),
      .ld   (xfer),
      .q    (nq[g])
    );
  end

  assign n0 = nq[0];
  assign n1 = nq[1];
  assign n2 = nq[2];
  assign n3 = nq[3];
  assign n4 = nq[4];
  assign n5 = nq[5];
  assign n6 = nq[6];
  assign n7 = nq[7];
endmodule
